instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface. Drives the byte address into the combinational instruction memory and captures the returned 32-bit little-endian word.
- Buffers fetched words with their PCs in a small prefetch FIFO.
- Hands words to decode over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and reloading the PC.

---
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the PC into a combinational instruction
// memory, buffers fetched {pc, word} pairs in a small prefetch FIFO and
// presents the head to decode over valid/ready. Branch redirects flush the
// FIFO and reload the PC.
// Optional build macro FETCH_STATS_EN adds fetch_count / flush_count outputs.
module instruction_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter int          PC_STEP  = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] output_address,
   input  logic [31:0] input_data,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
`ifdef FETCH_STATS_EN
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count,
`endif
   output logic [63:0] out_pc
);

   localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [63:0] STEP     = 64'(PC_STEP);

   logic [63:0]      pc;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      instr_buf [DEPTH];
   logic [63:0]      pc_buf    [DEPTH];
   logic             push;
   logic             pop;

   assign output_address = pc;
   assign out_valid      = (count != '0);
   // Data storage is not reset, so mask the head with valid to keep the
   // outputs at zero whenever the FIFO is empty (including after reset).
   assign out_instruction = out_valid ? instr_buf[rd_ptr] : 32'h0;
   assign out_pc          = out_valid ? pc_buf[rd_ptr]    : 64'h0;

   assign pop  = out_valid & out_ready & ~branch_taken;
   assign push = ~branch_taken & ((count < FULL_CNT) | pop);

   // Control state: PC, pointers and occupancy; redirect beats push/pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (branch_taken) begin
         pc     <= {branch_target[63:2], 2'b00};
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc     <= pc + STEP;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO payload: capture the fetched word alongside the PC it came from.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         instr_buf[wr_ptr] <= input_data;
         pc_buf[wr_ptr]    <= pc;
      end
   end

`ifdef FETCH_STATS_EN
   // Statistics: pushes counted as fetches, discarded entries as flushes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= 32'h0;
         flush_count <= 32'h0;
      end else begin
         if (push) begin
            fetch_count <= fetch_count + 32'h1;
         end
         if (branch_taken) begin
            flush_count <= flush_count + 32'(count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: sequential fetch, FIFO
// fill/hold, redirect with cancelled handshake, mid-run reset and PC wrap.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] output_address;
   logic [31:0] input_data;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [63:0] out_pc;

   logic        rst2_n;
   logic [63:0] output_address2;
   logic [31:0] input_data2;
   logic        out_valid2;
   logic [31:0] out_instruction2;
   logic [63:0] out_pc2;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, flush_count, fetch_count2, flush_count2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [63:0] a);
      case (a)
         64'd0:   imem = 32'h8b1f03e5;
         64'd4:   imem = 32'hf84000a4;
         64'd8:   imem = 32'h8b040086;
         64'd12:  imem = 32'hf80010a6;
         64'd16:  imem = 32'hf84010a6;
         default: imem = 32'h0;
      endcase
   endfunction

   assign input_data  = imem(output_address);
   assign input_data2 = imem(output_address2);

   instruction_fetch_unit #(.DEPTH(4), .PC_STEP(4), .RESET_PC(64'h0)) dut (
      .clk(clk), .rst_n(rst_n), .output_address(output_address),
      .input_data(input_data), .branch_taken(branch_taken),
      .branch_target(branch_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_instruction(out_instruction),
`ifdef FETCH_STATS_EN
      .fetch_count(fetch_count), .flush_count(flush_count),
`endif
      .out_pc(out_pc)
   );

   instruction_fetch_unit #(.DEPTH(4), .PC_STEP(4),
                            .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .output_address(output_address2),
      .input_data(input_data2), .branch_taken(1'b0),
      .branch_target(64'h0), .out_valid(out_valid2),
      .out_ready(1'b1), .out_instruction(out_instruction2),
`ifdef FETCH_STATS_EN
      .fetch_count(fetch_count2), .flush_count(flush_count2),
`endif
      .out_pc(out_pc2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] seq_word [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      seq_word[0] = 32'h8b1f03e5; seq_word[1] = 32'hf84000a4;
      seq_word[2] = 32'h8b040086; seq_word[3] = 32'hf80010a6;
      seq_word[4] = 32'hf84010a6; seq_word[5] = 32'h00000000;

      rst_n = 1'b0; rst2_n = 1'b0; out_ready = 1'b1;
      branch_taken = 1'b0; branch_target = 64'h0;

      // Reset held two cycles
      step(); step();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_instr", 64'(out_instruction), 64'd0);
      check("rst_pc", out_pc, 64'd0);
      check("rst_addr", output_address, 64'd0);
`ifdef FETCH_STATS_EN
      check("rst_fetch_cnt", 64'(fetch_count), 64'd0);
`endif
      rst_n = 1'b1;

      // Sequential stream with decode always ready
      step();
      for (int i = 0; i < 6; i++) begin
         check($sformatf("seq_valid%0d", i), 64'(out_valid), 64'd1);
         check($sformatf("seq_pc%0d", i), out_pc, 64'(4 * i));
         check($sformatf("seq_instr%0d", i), 64'(out_instruction), 64'(seq_word[i]));
         step();
      end

      // Fill with decode stalled
      rst_n = 1'b0; out_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step(); step(); step(); step();
      check("full_addr", output_address, 64'd16);
      check("full_head_pc", out_pc, 64'd0);
      step(); step();
      check("full_hold_addr", output_address, 64'd16);
      check("full_hold_pc", out_pc, 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("full_pop_addr", output_address, 64'd20);
      check("full_pop_pc", out_pc, 64'd4);
      check("full_pop_instr", 64'(out_instruction), 64'h0000_0000_f840_00a4);

      // Redirect while full, with a handshake offered in the same cycle
      branch_taken = 1'b1; branch_target = 64'h0000_0000_0000_000E; out_ready = 1'b1;
      step();
      branch_taken = 1'b0; out_ready = 1'b0;
      check("br_valid", 64'(out_valid), 64'd0);
      check("br_addr", output_address, 64'hC);
`ifdef FETCH_STATS_EN
      check("br_flush_cnt", 64'(flush_count), 64'd4);
      check("br_fetch_cnt", 64'(fetch_count), 64'd5);
`endif
      step();
      check("br_head_valid", 64'(out_valid), 64'd1);
      check("br_head_pc", out_pc, 64'd12);
      check("br_head_instr", 64'(out_instruction), 64'h0000_0000_f800_10a6);

      // Three entries buffered, then a one-cycle reset pulse
      step(); step();
      check("pre_rst_pc", out_pc, 64'd12);
      check("pre_rst_addr", output_address, 64'd24);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_addr", output_address, 64'd0);
      check("mid_rst_pc", out_pc, 64'd0);
`ifdef FETCH_STATS_EN
      check("mid_rst_fetch_cnt", 64'(fetch_count), 64'd0);
      check("mid_rst_flush_cnt", 64'(flush_count), 64'd0);
`endif
      step();
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_instr", 64'(out_instruction), 64'h0000_0000_8b1f_03e5);

      // PC wrap on the second instance
      check("wrap_rst_addr", output_address2, 64'hFFFF_FFFF_FFFF_FFFC);
      rst2_n = 1'b1;
      step();
      check("wrap_pc0", out_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      check("wrap_pc1", out_pc2, 64'h0);
      check("wrap_instr1", 64'(out_instruction2), 64'h0000_0000_8b1f_03e5);
      step();
      check("wrap_pc2", out_pc2, 64'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
